// File: rtl/alu_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the ALU issue sequencer.
// ALU_ISSUE_TRAP_EN adds a TRAP state entered on an illegal opcode.
package alu_pkg;

  localparam logic [3:0] OP_LOADI = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_GT    = 4'b0110;
  localparam logic [3:0] OP_LT    = 4'b0111;
  localparam logic [3:0] OP_ADD   = 4'b1010;
  localparam logic [3:0] OP_SUB   = 4'b1011;
  localparam logic [3:0] OP_SHR   = 4'b1101;
  localparam logic [3:0] OP_SHL   = 4'b1110;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

`ifdef ALU_ISSUE_TRAP_EN
  typedef enum logic [2:0] {StIdle, StDecode, StExec, StWb, StTrap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;
`endif

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_GT, OP_LT, OP_ADD, OP_SUB, OP_SHR, OP_SHL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_cmp_op(input logic [3:0] op);
    return (op == OP_GT) || (op == OP_LT);
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Instruction handshake, ALU drive/result and writeback bundle of the issue sequencer.
// slave = sequencer side, master = environment side (instruction source + ALU).
interface alu_issue_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [15:0]      instr;
  logic [3:0]       alu_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [31:0]      alu_x;
  logic [31:0]      alu_y;
  logic             wb_valid;
  logic [3:0]       wb_addr;
  logic [3:0]       wb_data;
  logic             carry_flag;
  logic             illegal_op;
  logic             busy;
  logic [CNT_W-1:0] retired_count;

  modport slave (
    input  instr_valid, instr, alu_x, alu_y,
    output instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data,
           carry_flag, illegal_op, busy, retired_count
  );

  modport master (
    output instr_valid, instr, alu_x, alu_y,
    input  instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data,
           carry_flag, illegal_op, busy, retired_count
  );
endinterface

// File: rtl/alu_regfile.sv
// Register file: NREGS x DATA_W, two combinational read ports, one synchronous write port,
// asynchronously cleared.
module alu_regfile #(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  output logic [DATA_W-1:0]        rdata1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [DATA_W-1:0]        rdata2,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata
);
  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];
endmodule

// File: rtl/alu_issue_seq.sv
// Single-issue sequencer: IDLE -> DECODE -> EXEC -> WB around a combinational 4-bit ALU.
// Define ALU_ISSUE_TRAP_EN to park in TRAP after an illegal opcode until trap_clear.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ALU_ISSUE_TRAP_EN
  input  logic trap_clear,
`endif
  alu_issue_seq_if.slave bus
);
  state_e            state_q;
  logic [15:0]       instr_q;
  logic [3:0]        alu_op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic              wb_valid_q;
  logic [3:0]        wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              carry_q, illegal_q, ready_q, busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata1, rdata2;

  logic [3:0] opcode, rd;
  assign opcode = instr_q[OPC_MSB:OPC_LSB];
  assign rd     = instr_q[RD_MSB:RD_LSB];

  // Write lands at the end of WB, so the next instruction's DECODE sees it.
  alu_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (instr_q[RS1_MSB:RS1_LSB]),
    .rdata1 (rdata1),
    .raddr2 (instr_q[RS2_MSB:RS2_LSB]),
    .rdata2 (rdata2),
    .we     (state_q == StWb),
    .waddr  (wb_addr_q),
    .wdata  (wb_data_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      carry_q    <= 1'b0;
      illegal_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state_q <= StDecode;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StDecode: begin
          if (is_alu_op(opcode)) begin
            alu_op_q <= opcode;
            alu_a_q  <= rdata1;
            alu_b_q  <= rdata2;
            state_q  <= StExec;
          end else if (opcode == OP_LOADI) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd;
            wb_data_q  <= instr_q[RS1_MSB:RS1_LSB];
            state_q    <= StWb;
          end else begin
            illegal_q <= 1'b1;
`ifdef ALU_ISSUE_TRAP_EN
            state_q   <= StTrap;
`else
            state_q   <= StIdle;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`endif
          end
        end
        StExec: begin
          wb_valid_q <= 1'b1;
          wb_addr_q  <= rd;
          // Compares report only bit 0; everything else is truncated to the register width.
          wb_data_q  <= is_cmp_op(alu_op_q) ? {{(DATA_W-1){1'b0}}, bus.alu_x[0]}
                                            : bus.alu_x[DATA_W-1:0];
          if (alu_op_q == OP_ADD) carry_q <= bus.alu_y[0];
          state_q    <= StWb;
        end
        StWb: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
`ifdef ALU_ISSUE_TRAP_EN
        StTrap: begin
          if (trap_clear) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready   = ready_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_addr       = wb_addr_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.carry_flag    = carry_q;
  assign bus.illegal_op    = illegal_q;
  assign bus.busy          = busy_q;
  assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: a behavioural ALU feeds alu_x/alu_y, a scoreboard
// queue holds expected writebacks and a negedge monitor checks every wb_valid pulse.
module tb_alu_issue_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic trap_clear;
  int   n_vec;
  int   n_fail;
  int   exp_retired;
  exp_t sb_q[$];

  alu_issue_seq_if bus ();

  alu_issue_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ALU_ISSUE_TRAP_EN
    .trap_clear (trap_clear),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU; compare results carry junk in x[31:1] that the sequencer must ignore.
  always_comb begin
    logic [4:0] sum;
    sum       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_x = '0;
    bus.alu_y = '0;
    case (bus.alu_op)
      OP_AND: bus.alu_x = {28'b0, bus.alu_a & bus.alu_b};
      OP_OR:  bus.alu_x = {28'b0, bus.alu_a | bus.alu_b};
      OP_XOR: bus.alu_x = {28'b0, bus.alu_a ^ bus.alu_b};
      OP_GT:  bus.alu_x = 32'hAAAA_AAAA | {31'b0, bus.alu_a > bus.alu_b};
      OP_LT:  bus.alu_x = 32'hAAAA_AAAA | {31'b0, bus.alu_a < bus.alu_b};
      OP_ADD: begin
        bus.alu_x = {27'b0, sum};
        bus.alu_y = {31'b0, sum[4]};
      end
      OP_SUB: begin
        bus.alu_x = {28'b0, bus.alu_a - bus.alu_b};
        bus.alu_y = {31'b0, bus.alu_a < bus.alu_b};
      end
      OP_SHR: bus.alu_x = {28'b0, bus.alu_a} >> bus.alu_b;
      OP_SHL: bus.alu_x = {28'b0, bus.alu_a} << bus.alu_b;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {op, rd, s1, s2};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.wb_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wb_unexpected: wb_valid addr %0d data %0d, none expected",
                 bus.wb_addr, bus.wb_data);
      end else begin
        e = sb_q.pop_front();
        check("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
        check("wb_data", 32'(bus.wb_data), 32'(e.data));
      end
    end
  end

  // Entered and left at a negedge with the DUT idle.
  task automatic issue(input logic [15:0] w, input logic [3:0] ea, input logic [3:0] ed,
                       input int lat, input string nm);
    int k;
    k = 0;
    while (!bus.instr_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    sb_q.push_back(exp_t'{ea, ed});
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    k = 1;
    while (!bus.wb_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_latency"}, 32'(k), 32'(lat));
    @(negedge clk);
    exp_retired++;
    check({nm, "_retired"}, 32'(bus.retired_count), 32'(exp_retired));
  endtask

  task automatic illegal_test(input logic [15:0] w, input string nm);
    int pulses;
    pulses = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.illegal_op) pulses++;
    end
    check({nm, "_pulses"}, 32'(pulses), 32'd1);
    check({nm, "_retired"}, 32'(bus.retired_count), 32'(exp_retired));
`ifdef ALU_ISSUE_TRAP_EN
    check({nm, "_trap_ready"}, 32'(bus.instr_ready), 32'd0);
    check({nm, "_trap_busy"}, 32'(bus.busy), 32'd1);
    trap_clear = 1'b1;
    @(negedge clk);
    trap_clear = 1'b0;
`endif
    check({nm, "_ready"}, 32'(bus.instr_ready), 32'd1);
    check({nm, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_ready"}, 32'(bus.instr_ready), 32'd1);
    check({nm, "_busy"}, 32'(bus.busy), 32'd0);
    check({nm, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    check({nm, "_illegal"}, 32'(bus.illegal_op), 32'd0);
    check({nm, "_carry"}, 32'(bus.carry_flag), 32'd0);
    check({nm, "_retired"}, 32'(bus.retired_count), 32'd0);
    check({nm, "_alu_in"}, 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_vec           = 0;
    n_fail          = 0;
    exp_retired     = 0;
    clk             = 1'b0;
    rst_n           = 1'b0;
    trap_clear      = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);

    // 9 + 7 = 16: truncated result 0 with carry out.
    issue(mk(OP_LOADI, 4'd1, 4'd9, 4'd0), 4'd1, 4'd9, 2, "loadi_r1");
    issue(mk(OP_LOADI, 4'd2, 4'd7, 4'd0), 4'd2, 4'd7, 2, "loadi_r2");
    issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), 4'd3, 4'd0, 3, "add_r3");
    check("add_carry", 32'(bus.carry_flag), 32'd1);
    check("retired_three", 32'(bus.retired_count), 32'd3);

    // r1 = 5, r2 = 3
    issue(mk(OP_LOADI, 4'd1, 4'd5, 4'd0), 4'd1, 4'd5, 2, "loadi_r1b");
    issue(mk(OP_LOADI, 4'd2, 4'd3, 4'd0), 4'd2, 4'd3, 2, "loadi_r2b");
    issue(mk(OP_GT,  4'd4,  4'd1, 4'd2), 4'd4,  4'd1, 3, "gt_r4");
    issue(mk(OP_LT,  4'd5,  4'd1, 4'd2), 4'd5,  4'd0, 3, "lt_r5");
    issue(mk(OP_SUB, 4'd6,  4'd1, 4'd2), 4'd6,  4'd2, 3, "sub_r6");
    check("sub_keeps_carry", 32'(bus.carry_flag), 32'd1);
    issue(mk(OP_SHL, 4'd7,  4'd1, 4'd2), 4'd7,  4'd8, 3, "shl_r7");
    issue(mk(OP_AND, 4'd8,  4'd1, 4'd2), 4'd8,  4'd1, 3, "and_r8");
    issue(mk(OP_OR,  4'd9,  4'd1, 4'd2), 4'd9,  4'd7, 3, "or_r9");
    issue(mk(OP_XOR, 4'd10, 4'd1, 4'd2), 4'd10, 4'd6, 3, "xor_r10");
    issue(mk(OP_SHR, 4'd11, 4'd1, 4'd4), 4'd11, 4'd2, 3, "shr_r11");

    // rd == rs hazard: r1 = 4 + 4 = 8, then consumers must see 8.
    issue(mk(OP_LOADI, 4'd1, 4'd4, 4'd0), 4'd1, 4'd4, 2, "loadi_r1c");
    issue(mk(OP_ADD, 4'd1,  4'd1, 4'd1), 4'd1,  4'd8, 3, "add_r1_self");
    check("add_no_carry", 32'(bus.carry_flag), 32'd0);
    issue(mk(OP_XOR, 4'd2,  4'd1, 4'd1), 4'd2,  4'd0, 3, "xor_r2_self");
    issue(mk(OP_ADD, 4'd12, 4'd1, 4'd4), 4'd12, 4'd9, 3, "add_r12");

    illegal_test(mk(4'b1111, 4'd3, 4'd1, 4'd2), "illegal_f");
    illegal_test(mk(4'b0000, 4'd5, 4'd1, 4'd2), "illegal_0");

    // instr_valid held high with a new word every cycle: only words seen in IDLE execute.
    for (int i = 0; i < 12; i++) begin
      check("stream_ready", 32'(bus.instr_ready), (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i % 4 == 0) begin
        sb_q.push_back(exp_t'{4'(i), 4'd0});
        exp_retired++;
      end
      bus.instr_valid = 1'b1;
      bus.instr       = mk(OP_XOR, 4'(i), 4'd0, 4'd0);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check("stream_retired", 32'(bus.retired_count), 32'(exp_retired));

    // 15 + 15 = 30 sets carry so the reset below visibly clears it.
    issue(mk(OP_LOADI, 4'd14, 4'd15, 4'd0), 4'd14, 4'd15, 2, "loadi_r14");
    issue(mk(OP_ADD, 4'd15, 4'd14, 4'd14), 4'd15, 4'd14, 3, "add_r15");
    check("add_r15_carry", 32'(bus.carry_flag), 32'd1);

    // Reset during EXEC of an ADD: no writeback, everything back to reset values.
    bus.instr_valid = 1'b1;
    bus.instr       = mk(OP_ADD, 4'd3, 4'd14, 4'd14);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("exec_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_exec_rst");
    @(negedge clk);
    rst_n       = 1'b1;
    exp_retired = 0;
    @(negedge clk);
    issue(mk(OP_ADD, 4'd3, 4'd14, 4'd14), 4'd3, 4'd0, 3, "post_rst_add");
    check("post_rst_carry", 32'(bus.carry_flag), 32'd0);
    issue(mk(OP_OR, 4'd5, 4'd7, 4'd15), 4'd5, 4'd0, 3, "post_rst_or");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
